load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage initiator that drives the word-addressed data memory (memory_unit) on behalf of the pipeline. It accepts one load/store request at a time and issues MemRead/MemWrite cycles. It performs byte/halfword lane selection with sign/zero extension on loads, and read-modify-write for sub-word stores, because memory_unit only reads and writes full 32-bit words. It returns a single-cycle response, with an error flag for misaligned accesses.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle and able to accept
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned/reserved-size request; valid with rsp_valid
address  out  ADDR_W  to memory: word address, low 2 bits always 0
write_data  out  DATA_W  to memory: full word to write
MemWrite  out  1  to memory: write strobe
MemRead  out  1  to memory: read strobe
read_data  in  DATA_W  from memory: registered read, valid the cycle after MemRead

Behaviour:
- All outputs registered.
- Reset (async, rst_n=0): state IDLE. req_ready, rsp_valid, rsp_err, MemWrite, MemRead all 0. address, write_data, rsp_rdata all 0.
- req_ready=1 whenever state==IDLE and not in reset; 0 in all other states. It first rises on the first clk edge after rst_n deasserts.
- Handshake: a request is accepted in the cycle req_valid&&req_ready (cycle 0). All request fields are captured at that edge; later input changes are ignored.
- address = {req_addr[ADDR_W-1:2],2'b00}, held stable from cycle 1 until return to IDLE.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- Misaligned is defined as: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Flow: IDLE -> RESP. rsp_valid=1 and rsp_err=1 in cycle 1. No MemRead/MemWrite ever asserted.
- Load: IDLE -> RD_ISSUE (cycle 1, MemRead=1) -> RD_WAIT (cycle 2, read_data sampled at end of cycle) -> RESP (cycle 3, rsp_valid=1).
- Word store: IDLE -> WR_ISSUE (cycle 1, MemWrite=1, write_data=req_wdata) -> RESP (cycle 2).
- Sub-word store: IDLE -> RD_ISSUE (cycle 1) -> RD_WAIT (cycle 2, merge) -> WR_ISSUE (cycle 3, merged word written) -> RESP (cycle 4).
- Byte lanes are little-endian.
  - Byte lane = addr[1:0]: lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Half lane = addr[1]: 0 = bits [15:0], 1 = bits [31:16].
- Merge: the old word is replaced only in the selected lane(s), with req_wdata[7:0] or req_wdata[15:0].
- Load extension:
  - Byte: bit 7 of the selected lane replicated to bits [31:8] when req_unsigned=0, else zeros.
  - Half: bit 15 of the selected half replicated to bits [31:16] when req_unsigned=0, else zeros.
  - Word: no extension.
- RESP -> IDLE unconditionally. MemRead and MemWrite are each exactly one cycle wide and are never high together.
- rsp_rdata and rsp_err are held until the next rsp_valid. Bench checks them only while rsp_valid=1.
- Back-to-back requests: the next accept is no earlier than the cycle after RESP.
- Reset mid-operation:
  - All strobes drop immediately (async).
  - No response is issued for the aborted request.
  - A sub-word store aborted after RD_ISSUE leaves memory unchanged.

Test Plan:
- Word store/load: SW addr 0x4 data 0x00000011 -> MemWrite high only in cycle 1 with address 0x4, write_data 0x11; rsp_valid in cycle 2. Then LW 0x4 -> MemRead in cycle 1; rsp_rdata 0x00000011 in cycle 3.
- Byte store RMW: memory word 0x8 = 0x11223344; SB addr 0x9 data 0xAB -> MemRead in cycle 1, MemWrite in cycle 3 with write_data 0x1122AB44; rsp_valid in cycle 4.
- Load extension: with word 0x8 = 0x1122AB44:
  - LB 0x9 -> 0xFFFFFFAB.
  - LBU 0x9 -> 0x000000AB.
  - LH 0xA -> 0x00001122.
  - SH 0xA data 0x8001, then LH 0xA -> 0xFFFF8001.
- Misaligned: LW 0x6, LH 0x5, SW 0xD, size=11 -> rsp_err=1 and rsp_valid in cycle 1; MemRead/MemWrite stay 0; memory unchanged.
- Handshake: hold req_valid=1 continuously with 3 loads -> req_ready low from cycle 1 through RESP; each request accepted exactly once; responses arrive in order.
- Reset mid-op: assert rst_n=0 during RD_WAIT of SB 0x9 -> MemRead/MemWrite/rsp_valid 0 immediately; word 0x8 unchanged; req_ready=1 one edge after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator for a word-addressed data memory.
// Does lane select + extension on loads and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              req_ready_q, req_ready_d;

    logic              misaligned_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [DATA_W-1:0] load_ext_c;
    logic [DATA_W-1:0] merged_c;

    assign misaligned_c = (req_size == 2'b11)
                        | ((req_size == SZ_HALF) & req_addr[0])
                        | ((req_size == SZ_WORD) & (|req_addr[1:0]));

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        byte_c     = read_data[{lane_q, 3'b000} +: 8];
        half_c     = read_data[{lane_q[1], 4'b0000} +: 16];
        load_ext_c = read_data;
        merged_c   = read_data;
        case (size_q)
            SZ_BYTE: begin
                load_ext_c = {{(DATA_W-8){byte_c[7] & ~uns_q}}, byte_c};
                merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_ext_c = {{(DATA_W-16){half_c[15] & ~uns_q}}, half_c};
                merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d   = req_write;
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    lane_d    = req_addr[1:0];
                    wdata_d   = req_wdata[15:0];
                    address_d = {req_addr[ADDR_W-1:2], 2'b00};
                    if (misaligned_c) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_d      = WR_ISSUE;
                        write_data_d = req_wdata;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (write_q) begin
                    state_d      = WR_ISSUE;
                    write_data_d = merged_c;
                end else begin
                    state_d     = RESP;
                    rsp_rdata_d = load_ext_c;
                    rsp_err_d   = 1'b0;
                end
            end
            WR_ISSUE: begin
                state_d     = RESP;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes follow the state being entered so they line up with it
        mem_read_d  = (state_d == RD_ISSUE);
        mem_write_d = (state_d == WR_ISSUE);
        rsp_valid_d = (state_d == RESP);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign MemWrite   = mem_write_q;
    assign MemRead    = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model plus a byte-array reference model.
module tb_load_store_unit;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_WORDS = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] read_data = '0;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .address      (address),
        .write_data   (write_data),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .read_data    (read_data)
    );

    always #5 clk = ~clk;

    // Word-addressed memory with a registered read port
    logic [31:0] mem      [MEM_WORDS];
    logic [31:0] init_val [MEM_WORDS];
    logic        init_en = 1'b0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_val[i];
        end else begin
            if (MemWrite) mem[address[7:2]] <= write_data;
            if (MemRead)  read_data <= mem[address[7:2]];
        end
    end

    logic [7:0]  ref_b [MEM_WORDS*4];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          last_wait;
    logic [31:0] last_rsp;
    logic [3:0]  ctl;

    assign ctl = {req_ready, MemRead, MemWrite, rsp_valid};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endfunction

    // One request; hold=1 keeps req_valid high so the caller can chain the next one
    task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int          a;
        int          nb;
        int          lat;
        int          waited;
        bit          err;
        bit          rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_ctl;

        a      = int'(addr[7:0]);
        nb     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        err    = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        exp_rd = '0;
        exp_wd = '0;
        if (err) begin
            lat = 1;
        end else if (wr) begin
            for (int i = 0; i < nb; i++) ref_b[a+i] = wd[8*i +: 8];
            exp_wd = ref_word(a & ~3);
            lat    = (sz == 2'b10) ? 2 : 4;
        end else begin
            for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_b[a+i];
            if (!uns && nb < 4 && exp_rd[8*nb-1])
                for (int i = 8*nb; i < 32; i++) exp_rd[i] = 1'b1;
            lat = 3;
        end
        rd = !err && (!wr || sz != 2'b10);

        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        waited       = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        check("accept_wait", 32'(waited < 20), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (!hold && k == 1) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_size  = 2'($urandom);
            end
            exp_ctl = {1'b0, rd && k == 1, wr && !err && k == lat - 1, k == lat};
            check($sformatf("ctl_c%0d_a%h", k, addr), 32'(ctl), 32'(exp_ctl));
            check($sformatf("addr_c%0d", k), address, {addr[31:2], 2'b00});
            if (exp_ctl[1]) check($sformatf("wdata_a%h", addr), write_data, exp_wd);
            if (k == lat) begin
                last_rsp = rsp_rdata;
                check($sformatf("rdata_a%h", addr), rsp_rdata, exp_rd);
                check($sformatf("err_a%h", addr), 32'(rsp_err), 32'(err));
            end
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'({req_ready, rsp_valid}), 32'b10);
        end
    endtask

    initial begin
        int mism;
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            init_val[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_b[4*i+b] = init_val[i][8*b +: 8];
        end
        init_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_en = 1'b0;
        check("rst_ctl", 32'(ctl), 32'd0);
        check("rst_addr", address, 32'd0);
        check("rst_wdata", write_data, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_pre_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_post_edge", 32'(req_ready), 32'd1);

        // Word store then load
        txn(1'b1, 2'b10, 1'b0, 32'h4, 32'h11, 1'b0);
        gap(1);
        txn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
        check("lw_lit", last_rsp, 32'h11);
        gap(1);

        // Byte store RMW and load extension
        txn(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 1'b0);
        gap(1);
        txn(1'b1, 2'b00, 1'b0, 32'h9, 32'hAB, 1'b0);
        check("sb_mem_lit", mem[2], 32'h1122AB44);
        gap(1);
        txn(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 1'b0);
        check("lb_lit", last_rsp, 32'hFFFFFFAB);
        gap(1);
        txn(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b0);
        check("lbu_lit", last_rsp, 32'h000000AB);
        gap(1);
        txn(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 1'b0);
        check("lh_lit", last_rsp, 32'h00001122);
        gap(1);
        txn(1'b1, 2'b01, 1'b0, 32'hA, 32'h8001, 1'b0);
        gap(1);
        txn(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 1'b0);
        check("lh_neg_lit", last_rsp, 32'hFFFF8001);
        gap(1);

        // Misaligned and reserved size
        txn(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b0);
        gap(1);
        txn(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 1'b0);
        gap(1);
        txn(1'b1, 2'b10, 1'b0, 32'hD, 32'hDEADBEEF, 1'b0);
        gap(1);
        txn(1'b1, 2'b11, 1'b0, 32'h8, 32'hCAFEF00D, 1'b0);
        check("mis_mem_c", mem[3], ref_word(12));
        check("mis_mem_8", mem[2], ref_word(8));
        gap(1);

        // Back-to-back with req_valid held high
        txn(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1);
        txn(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 1'b1);
        check("b2b_wait1", 32'(last_wait), 32'd1);
        txn(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 1'b1);
        check("b2b_wait2", 32'(last_wait), 32'd1);
        req_valid = 1'b0;
        gap(2);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
                $urandom, 1'b0);
            gap(int'($urandom_range(1, 2)));
        end

        // Reset during RD_WAIT of a byte store
        req_write    = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h9;
        req_wdata    = 32'h5A;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_rd_issue", 32'(MemRead), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ctl", 32'(ctl), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'({req_ready, rsp_valid}), 32'b10);
        gap(3);
        check("abort_mem", mem[2], ref_word(8));
        txn(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0);
        gap(1);

        mism = 0;
        for (int i = 0; i < int'(MEM_WORDS); i++)
            if (mem[i] !== ref_word(4*i)) mism++;
        check("final_mem_mismatches", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
